// File: rtl/booth_pkg.sv
// Shared constants, Booth digit encoding and the radix-4 group decoder for booth_mul.
package booth_pkg;

    localparam int WIDTH = 32;
    localparam int NPP   = 16;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_POS1,
        BD_POS2,
        BD_NEG1,
        BD_NEG2
    } booth_digit_e;

    function automatic booth_digit_e booth_decode(input logic [2:0] grp);
        booth_digit_e digit;
        case (grp)
            3'b001, 3'b010: digit = BD_POS1;
            3'b011:         digit = BD_POS2;
            3'b100:         digit = BD_NEG2;
            3'b101, 3'b110: digit = BD_NEG1;
            default:        digit = BD_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_mul_if.sv
// Operand/result bundle for booth_mul, including the sixteen debug partial-product taps.
interface booth_mul_if;
    import booth_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [PW-1:0]    m;
    logic [PW-1:0]    shift0,  shift1,  shift2,  shift3;
    logic [PW-1:0]    shift4,  shift5,  shift6,  shift7;
    logic [PW-1:0]    shift8,  shift9,  shift10, shift11;
    logic [PW-1:0]    shift12, shift13, shift14, shift15;

    modport master (
        output in_valid, a, b,
        input  out_valid, m,
        input  shift0, shift1, shift2, shift3, shift4, shift5, shift6, shift7,
        input  shift8, shift9, shift10, shift11, shift12, shift13, shift14, shift15
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, m,
        output shift0, shift1, shift2, shift3, shift4, shift5, shift6, shift7,
        output shift8, shift9, shift10, shift11, shift12, shift13, shift14, shift15
    );

endinterface

// File: rtl/booth_mul_pp_gen.sv
// One radix-4 Booth partial product: digit * a, sign-extended to 64 bits and weighted by 4^K.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int K = 0
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [2:0]           grp,
    output logic signed [PW-1:0] pp
);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] mag;
    booth_digit_e         digit;

    always_comb begin
        a_ext = $signed({{WIDTH{1'b0}}, a});
        digit = booth_decode(grp);
        case (digit)
            BD_POS1: mag = a_ext;
            BD_POS2: mag = a_ext <<< 1;
            BD_NEG1: mag = ~a_ext + 64'sd1;
            BD_NEG2: mag = ~(a_ext <<< 1) + 64'sd1;
            default: mag = '0;
        endcase
        pp = mag <<< (2 * K);
    end

endmodule

// File: rtl/booth_mul.sv
// Unsigned 32x32 radix-4 Booth multiplier with one registered output stage.
// Define BOOTH_DEBUG_EN to build registered partial-product taps on shift0..shift15.
module booth_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    booth_mul_if.slave  bus
);

    logic [WIDTH:0]       b_ext;
    logic signed [PW-1:0] pp_p0 [NPP];
    logic signed [PW-1:0] corr_p0;
    logic signed [PW-1:0] sum_p0;

    logic                 vld_p1;
    logic signed [PW-1:0] m_p1;
    logic signed [PW-1:0] shift_p1 [NPP];

    assign b_ext = {bus.b, 1'b0};

    for (genvar k = 0; k < NPP; k++) begin : g_pp
        booth_pp_gen #(.K(k)) u_pp (
            .a   (bus.a),
            .grp (b_ext[2*k+2 : 2*k]),
            .pp  (pp_p0[k])
        );
    end

    // Recoding treats b[31] as a sign bit; adding a*2^32 restores the unsigned value.
    always_comb begin
        corr_p0 = bus.b[WIDTH-1] ? $signed({bus.a, {WIDTH{1'b0}}}) : '0;
        sum_p0  = corr_p0;
        for (int i = 0; i < NPP; i++) begin
            sum_p0 = sum_p0 + pp_p0[i];
        end
    end

    // ---- stage p0 -> p1: output registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            m_p1   <= '0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                m_p1 <= sum_p0;
            end
        end
    end

`ifdef BOOTH_DEBUG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPP; i++) begin
                shift_p1[i] <= '0;
            end
        end else if (bus.in_valid) begin
            for (int i = 0; i < NPP; i++) begin
                shift_p1[i] <= pp_p0[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NPP; i++) begin
            shift_p1[i] = '0;
        end
    end
`endif

    assign bus.out_valid = vld_p1;
    assign bus.m         = $unsigned(m_p1);
    assign bus.shift0    = $unsigned(shift_p1[0]);
    assign bus.shift1    = $unsigned(shift_p1[1]);
    assign bus.shift2    = $unsigned(shift_p1[2]);
    assign bus.shift3    = $unsigned(shift_p1[3]);
    assign bus.shift4    = $unsigned(shift_p1[4]);
    assign bus.shift5    = $unsigned(shift_p1[5]);
    assign bus.shift6    = $unsigned(shift_p1[6]);
    assign bus.shift7    = $unsigned(shift_p1[7]);
    assign bus.shift8    = $unsigned(shift_p1[8]);
    assign bus.shift9    = $unsigned(shift_p1[9]);
    assign bus.shift10   = $unsigned(shift_p1[10]);
    assign bus.shift11   = $unsigned(shift_p1[11]);
    assign bus.shift12   = $unsigned(shift_p1[12]);
    assign bus.shift13   = $unsigned(shift_p1[13]);
    assign bus.shift14   = $unsigned(shift_p1[14]);
    assign bus.shift15   = $unsigned(shift_p1[15]);

endmodule

// File: tb/tb_booth_mul.sv
// Scoreboard bench for booth_mul: directed corner products, hold, resets and a random back-to-back stream.
module tb_booth_mul;
    import booth_pkg::*;

    typedef struct {
        logic [63:0]       m;
        logic              chk_shift;
        logic [15:0][63:0] shift;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic exp_vld = 1'b0;
    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [63:0] shift_obs [16];

    always #5 clk = ~clk;

    booth_mul_if bus();

    booth_mul #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign shift_obs[0]  = bus.shift0;
    assign shift_obs[1]  = bus.shift1;
    assign shift_obs[2]  = bus.shift2;
    assign shift_obs[3]  = bus.shift3;
    assign shift_obs[4]  = bus.shift4;
    assign shift_obs[5]  = bus.shift5;
    assign shift_obs[6]  = bus.shift6;
    assign shift_obs[7]  = bus.shift7;
    assign shift_obs[8]  = bus.shift8;
    assign shift_obs[9]  = bus.shift9;
    assign shift_obs[10] = bus.shift10;
    assign shift_obs[11] = bus.shift11;
    assign shift_obs[12] = bus.shift12;
    assign shift_obs[13] = bus.shift13;
    assign shift_obs[14] = bus.shift14;
    assign shift_obs[15] = bus.shift15;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input bit cs, input logic [15:0][63:0] sh);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        e.m          = 64'(a) * 64'(b);
`ifdef BOOTH_DEBUG_EN
        e.chk_shift  = cs;
        e.shift      = sh;
`else
        e.chk_shift  = 1'b1;
        e.shift      = '0;
`endif
        q.push_back(e);
    endtask

    // Reference for out_valid: one-cycle delay of in_valid, cleared by reset.
    always @(posedge clk) exp_vld <= rst_n && bus.in_valid;

    always @(negedge clk) begin
        exp_t e;
        chk("out_valid", {63'b0, bus.out_valid}, {63'b0, exp_vld});
        if (bus.out_valid) begin
            chk("sb_nonempty", {63'b0, (q.size() != 0)}, 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("m", bus.m, e.m);
                if (e.chk_shift) begin
                    for (int k = 0; k < 16; k++) begin
                        chk($sformatf("shift%0d", k), shift_obs[k], e.shift[k]);
                    end
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog cycle budget expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0][63:0] sh;
        logic [31:0] ra, rb;

        bus.in_valid = 1'b1;
        bus.a        = 32'd5;
        bus.b        = 32'd7;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_m", bus.m, 64'd0);
        for (int k = 0; k < 16; k++) chk($sformatf("rst_shift%0d", k), shift_obs[k], 64'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;

        sh = '0; sh[0] = 64'hFFFFFFFFFFFFFFFE; sh[1] = 64'h4;
        drive(32'd1, 32'd2, 1'b1, sh);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h9ABC_DEF0;
        @(negedge clk);
        chk("hold_m", bus.m, 64'h2);
`ifdef BOOTH_DEBUG_EN
        chk("hold_shift0", bus.shift0, 64'hFFFFFFFFFFFFFFFE);
`else
        chk("hold_shift0", bus.shift0, 64'h0);
`endif

        sh = '0; sh[0] = 64'hFFFFFFFF00000001;
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, sh);
        sh = '0; sh[15] = 64'hFFFFFFFF80000000;
        drive(32'd1, 32'h80000000, 1'b1, sh);
        sh = '0; sh[0] = 64'hFFFFFFFFFFFF0001; sh[8] = 64'h00000000FFFF0000;
        drive(32'h0000FFFF, 32'h0000FFFF, 1'b1, sh);
        sh = '0;
        drive(32'h0, 32'hFFFFFFFF, 1'b1, sh);

        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                @(negedge clk);
                rst_n        = 1'b0;
                bus.in_valid = 1'b1;
                bus.a        = $urandom;
                bus.b        = $urandom;
                @(negedge clk);
                chk("rst_mid_vld", {63'b0, bus.out_valid}, 64'd0);
                chk("rst_mid_m", bus.m, 64'd0);
                rst_n        = 1'b1;
                bus.in_valid = 1'b0;
            end
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) ra[31] = 1'b1;
            if (i % 3 == 0) rb[31] = 1'b1;
            drive(ra, rb, 1'b0, '0);
        end

        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
